pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, width of PC and all address ports.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, PC value after reset.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, power of two ≥2, return-address-stack entries.
REQ-004 SHALL have port clk  in  1  clock, all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port stall  in  1  hold PC this cycle.
REQ-007 SHALL have port PCsrc  in  2  next-PC select: 00 seq, 01 branch, 10 jalr, 11 trap.
REQ-008 SHALL have port ImmOp  in  ADDRESS_WIDTH  sign-extended immediate.
REQ-009 SHALL have port rs1  in  ADDRESS_WIDTH  jalr base register value.
REQ-010 SHALL have port trap_vec  in  ADDRESS_WIDTH  trap handler address.
REQ-011 SHALL have port is_call / is_ret  in  1 each  current instruction is call / return.
REQ-012 SHALL have port pc  out  ADDRESS_WIDTH  current PC (registered).
REQ-013 SHALL have port pc_plus4  out  ADDRESS_WIDTH  pc+4, combinational.
REQ-014 SHALL have port misalign  out  1  registered flag: last accepted target not 4-byte aligned.
REQ-015 SHALL have ports ras_top  out  ADDRESS_WIDTH and ras_valid  out  1  predicted return address.

Function
REQ-016 Next PC SHALL be: 00 pc+4; 01 pc+ImmOp; 10 (rs1+ImmOp) with bit0 cleared; 11 trap_vec; all mod 2^ADDRESS_WIDTH (wrap, no overflow flag).
REQ-017 stall=1 SHALL hold pc, misalign and RAS unchanged regardless of PCsrc, is_call, is_ret; one-cycle latency otherwise.
REQ-018 If computed target has bit1 set and PCsrc≠11, pc SHALL load trap_vec instead and misalign SHALL be 1 next cycle; any other accepted update SHALL clear misalign.
REQ-019 PCsrc=11 SHALL take priority over RAS operations: no push/pop that cycle.
REQ-020 is_call (unstalled) SHALL push pc_plus4; full stack SHALL overwrite oldest entry (circular), count saturates at RAS_DEPTH.
REQ-021 is_ret (unstalled) SHALL pop; pop when empty SHALL be ignored, count stays 0.
REQ-022 is_call and is_ret together SHALL replace top with pc_plus4, count unchanged (push onto empty stack if count=0).
REQ-023 ras_valid SHALL equal (count≠0); ras_top SHALL be top entry, 0 when empty.

Reset
REQ-024 rst SHALL immediately set pc=RESET_VECTOR, misalign=0, RAS count=0, pointer=0, ras_valid=0, independent of clk.
REQ-025 rst asserted mid-operation (including during stall) SHALL discard pending update; first update after deassertion uses inputs at the first rising edge with rst low.
REQ-026 RAS entry storage need not be cleared by reset.

Configuration
REQ-027 Macro PC_GEN_RAS_EN defined SHALL include RAS logic per REQ-020..023.
REQ-028 Without PC_GEN_RAS_EN, ras_top SHALL be tied 0, ras_valid tied 0, is_call/is_ret ignored, no RAS storage inferred; all other behaviour identical.

Verification
REQ-029 rst pulse then PCsrc=00 for 3 cycles -> pc 0x0, 0x4, 0x8, 0xC.
REQ-030 pc=0x100, PCsrc=01, ImmOp=0xFFFFFFF0 -> pc=0xF0; pc=0xFFFFFFFC, PCsrc=00 -> pc=0x0.
REQ-031 PCsrc=10, rs1=0x201, ImmOp=0x4 -> pc=0x204, misalign=0; rs1=0x202, ImmOp=0 -> pc=trap_vec, misalign=1.
REQ-032 stall=1 with PCsrc=01, is_call=1 for 2 cycles -> pc, RAS unchanged; release -> branch taken once.
REQ-033 (RAS_EN, depth 4) 5 calls at pc 0x0,0x10,0x20,0x30,0x40 -> ras_top=0x44; 4 rets -> ras_top 0x34,0x24,0x14 then ras_valid=0; 5th ret -> no change.
REQ-034 rst asserted mid-cycle while pc=0x80 -> pc=RESET_VECTOR before next edge, ras_valid=0, misalign=0.

Source files
------------

// File: rtl/pc_gen_if.sv
// Program-counter generator bus: next-PC select inputs, current PC and RAS prediction outputs.
interface pc_gen_if #(
  parameter int ADDRESS_WIDTH = 32
);
  logic                     stall;
  logic [1:0]               PCsrc;
  logic [ADDRESS_WIDTH-1:0] ImmOp;
  logic [ADDRESS_WIDTH-1:0] rs1;
  logic [ADDRESS_WIDTH-1:0] trap_vec;
  logic                     is_call;
  logic                     is_ret;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic                     misalign;
  logic [ADDRESS_WIDTH-1:0] ras_top;
  logic                     ras_valid;

  modport master (
    output stall, PCsrc, ImmOp, rs1, trap_vec, is_call, is_ret,
    input  pc, pc_plus4, misalign, ras_top, ras_valid
  );

  modport slave (
    input  stall, PCsrc, ImmOp, rs1, trap_vec, is_call, is_ret,
    output pc, pc_plus4, misalign, ras_top, ras_valid
  );
endinterface

// File: rtl/pc_gen.sv
// Program counter generator with misaligned-target trapping and an optional circular
// return-address stack, enabled by defining PC_GEN_RAS_EN.
module pc_gen #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0,
  parameter int                       RAS_DEPTH     = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);

  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic [ADDRESS_WIDTH-1:0] jalr_sum;
  logic [ADDRESS_WIDTH-1:0] target;
  logic [ADDRESS_WIDTH-1:0] next_pc;
  logic                     misalign_q;
  logic                     bad_align;

  assign pc_plus4 = pc_q + ADDRESS_WIDTH'(4);
  assign jalr_sum = bus.rs1 + bus.ImmOp;

  // A target with bit1 set is redirected to the trap handler; traps themselves are trusted.
  always_comb begin
    target = pc_plus4;
    unique case (bus.PCsrc)
      2'b00:   target = pc_plus4;
      2'b01:   target = pc_q + bus.ImmOp;
      2'b10:   target = {jalr_sum[ADDRESS_WIDTH-1:1], 1'b0};
      default: target = bus.trap_vec;
    endcase
    bad_align = target[1] && (bus.PCsrc != 2'b11);
    next_pc   = bad_align ? bus.trap_vec : target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
    end else if (!bus.stall) begin
      pc_q       <= next_pc;
      misalign_q <= bad_align;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.misalign = misalign_q;

`ifdef PC_GEN_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDRESS_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]         ras_ptr;
  logic [PTR_W-1:0]         top_idx;
  logic [CNT_W-1:0]         ras_cnt;
  logic                     ras_en;
  logic                     ras_empty;
  logic                     ras_full;
  logic                     do_push;
  logic                     do_replace;
  logic                     do_pop;

  // ras_ptr names the next free slot; the top is the slot just below it, modulo depth.
  assign top_idx   = ras_ptr - PTR_W'(1);
  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
  assign ras_en    = !bus.stall && (bus.PCsrc != 2'b11);

  // Call+return on an empty stack degenerates to a plain push.
  assign do_push    = ras_en && bus.is_call && (!bus.is_ret || ras_empty);
  assign do_replace = ras_en && bus.is_call && bus.is_ret && !ras_empty;
  assign do_pop     = ras_en && bus.is_ret && !bus.is_call && !ras_empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      ras_mem[ras_ptr] <= pc_plus4;
    end else if (do_replace) begin
      ras_mem[top_idx] <= pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (do_push) begin
      ras_ptr <= ras_ptr + PTR_W'(1);
      if (!ras_full) begin
        ras_cnt <= ras_cnt + CNT_W'(1);
      end
    end else if (do_pop) begin
      ras_ptr <= top_idx;
      ras_cnt <= ras_cnt - CNT_W'(1);
    end
  end

  assign bus.ras_valid = !ras_empty;
  assign bus.ras_top   = ras_empty ? '0 : ras_mem[top_idx];
`else
  logic unused_ras_inputs;

  assign unused_ras_inputs = bus.is_call ^ bus.is_ret;
  assign bus.ras_valid     = 1'b0;
  assign bus.ras_top       = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen: sequencing, branches, jalr, misalign trapping, stall,
// return-address stack (when PC_GEN_RAS_EN is defined) and asynchronous reset.
module tb_pc_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  pc_gen_if #(.ADDRESS_WIDTH(32)) dut_if ();

  pc_gen #(
    .ADDRESS_WIDTH(32),
    .RESET_VECTOR (32'h0),
    .RAS_DEPTH    (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dut_if.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    dut_if.stall = 1'b0; dut_if.PCsrc = 2'b00; dut_if.ImmOp = '0; dut_if.rs1 = '0;
    dut_if.trap_vec = 32'h1000; dut_if.is_call = 1'b0; dut_if.is_ret = 1'b0;
    rst = 1'b1;
    #12;
    n_compared++; if (dut_if.pc !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_pc: got %h want %h", dut_if.pc, 32'h0); end
    n_compared++; if (dut_if.misalign !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_misalign: got %b want 0", dut_if.misalign); end
    n_compared++; if (dut_if.ras_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_ras_valid: got %b want 0", dut_if.ras_valid); end
    n_compared++; if (dut_if.ras_top !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_ras_top: got %h want 0", dut_if.ras_top); end
    rst = 1'b0;
    tick();
    n_compared++; if (dut_if.pc !== 32'h4) begin n_mismatched++; $display("[TB] FAIL seq_1: got %h want %h", dut_if.pc, 32'h4); end
    tick();
    n_compared++; if (dut_if.pc !== 32'h8) begin n_mismatched++; $display("[TB] FAIL seq_2: got %h want %h", dut_if.pc, 32'h8); end
    tick();
    n_compared++; if (dut_if.pc !== 32'hC) begin n_mismatched++; $display("[TB] FAIL seq_3: got %h want %h", dut_if.pc, 32'hC); end
    n_compared++; if (dut_if.pc_plus4 !== 32'h10) begin n_mismatched++; $display("[TB] FAIL seq_plus4: got %h want %h", dut_if.pc_plus4, 32'h10); end
  endtask

  task automatic test_branch();
    dut_if.trap_vec = 32'h100; dut_if.PCsrc = 2'b11;
    tick();
    n_compared++; if (dut_if.pc !== 32'h100) begin n_mismatched++; $display("[TB] FAIL trap_load: got %h want %h", dut_if.pc, 32'h100); end
    dut_if.PCsrc = 2'b01; dut_if.ImmOp = 32'hFFFF_FFF0;
    tick();
    n_compared++; if (dut_if.pc !== 32'hF0) begin n_mismatched++; $display("[TB] FAIL branch_back: got %h want %h", dut_if.pc, 32'hF0); end
    n_compared++; if (dut_if.misalign !== 1'b0) begin n_mismatched++; $display("[TB] FAIL branch_misalign: got %b want 0", dut_if.misalign); end
    dut_if.trap_vec = 32'hFFFF_FFFC; dut_if.PCsrc = 2'b11;
    tick();
    n_compared++; if (dut_if.pc !== 32'hFFFF_FFFC) begin n_mismatched++; $display("[TB] FAIL trap_top: got %h want %h", dut_if.pc, 32'hFFFF_FFFC); end
    n_compared++; if (dut_if.pc_plus4 !== 32'h0) begin n_mismatched++; $display("[TB] FAIL plus4_wrap: got %h want 0", dut_if.pc_plus4); end
    dut_if.PCsrc = 2'b00;
    tick();
    n_compared++; if (dut_if.pc !== 32'h0) begin n_mismatched++; $display("[TB] FAIL seq_wrap: got %h want 0", dut_if.pc); end
  endtask

  task automatic test_jalr();
    dut_if.trap_vec = 32'h1000; dut_if.PCsrc = 2'b10; dut_if.rs1 = 32'h201; dut_if.ImmOp = 32'h4;
    tick();
    n_compared++; if (dut_if.pc !== 32'h204) begin n_mismatched++; $display("[TB] FAIL jalr_bit0: got %h want %h", dut_if.pc, 32'h204); end
    n_compared++; if (dut_if.misalign !== 1'b0) begin n_mismatched++; $display("[TB] FAIL jalr_ok_misalign: got %b want 0", dut_if.misalign); end
    dut_if.rs1 = 32'h202; dut_if.ImmOp = 32'h0;
    tick();
    n_compared++; if (dut_if.pc !== 32'h1000) begin n_mismatched++; $display("[TB] FAIL jalr_trap: got %h want %h", dut_if.pc, 32'h1000); end
    n_compared++; if (dut_if.misalign !== 1'b1) begin n_mismatched++; $display("[TB] FAIL jalr_misalign: got %b want 1", dut_if.misalign); end
    dut_if.rs1 = 32'h301;
    tick();
    n_compared++; if (dut_if.pc !== 32'h300) begin n_mismatched++; $display("[TB] FAIL jalr_clear: got %h want %h", dut_if.pc, 32'h300); end
    n_compared++; if (dut_if.misalign !== 1'b0) begin n_mismatched++; $display("[TB] FAIL misalign_clear: got %b want 0", dut_if.misalign); end
    dut_if.PCsrc = 2'b01; dut_if.ImmOp = 32'h2;
    tick();
    n_compared++; if (dut_if.pc !== 32'h1000) begin n_mismatched++; $display("[TB] FAIL branch_trap: got %h want %h", dut_if.pc, 32'h1000); end
    n_compared++; if (dut_if.misalign !== 1'b1) begin n_mismatched++; $display("[TB] FAIL branch_misalign_set: got %b want 1", dut_if.misalign); end
  endtask

  task automatic test_stall();
    dut_if.stall = 1'b1; dut_if.PCsrc = 2'b01; dut_if.ImmOp = 32'h40; dut_if.is_call = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_compared++; if (dut_if.pc !== 32'h1000) begin n_mismatched++; $display("[TB] FAIL stall_pc_%0d: got %h want %h", i, dut_if.pc, 32'h1000); end
      n_compared++; if (dut_if.misalign !== 1'b1) begin n_mismatched++; $display("[TB] FAIL stall_misalign_%0d: got %b want 1", i, dut_if.misalign); end
      n_compared++; if (dut_if.ras_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stall_ras_%0d: got %b want 0", i, dut_if.ras_valid); end
    end
    dut_if.stall = 1'b0; dut_if.is_call = 1'b0;
    tick();
    n_compared++; if (dut_if.pc !== 32'h1040) begin n_mismatched++; $display("[TB] FAIL stall_release: got %h want %h", dut_if.pc, 32'h1040); end
    n_compared++; if (dut_if.misalign !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stall_release_misalign: got %b want 0", dut_if.misalign); end
    dut_if.PCsrc = 2'b00;
    tick();
    n_compared++; if (dut_if.pc !== 32'h1044) begin n_mismatched++; $display("[TB] FAIL stall_once: got %h want %h", dut_if.pc, 32'h1044); end
  endtask

  task automatic test_ras();
    logic [31:0] exp_tops [3];
    exp_tops[0] = 32'h34; exp_tops[1] = 32'h24; exp_tops[2] = 32'h14;
    rst = 1'b1; #2; rst = 1'b0;
`ifdef PC_GEN_RAS_EN
    dut_if.PCsrc = 2'b01; dut_if.ImmOp = 32'h10; dut_if.is_call = 1'b1; dut_if.is_ret = 1'b0;
    tick();
    n_compared++; if (dut_if.ras_top !== 32'h4) begin n_mismatched++; $display("[TB] FAIL ras_first: got %h want %h", dut_if.ras_top, 32'h4); end
    for (int i = 0; i < 4; i++) tick();
    n_compared++; if (dut_if.ras_top !== 32'h44) begin n_mismatched++; $display("[TB] FAIL ras_full_top: got %h want %h", dut_if.ras_top, 32'h44); end
    n_compared++; if (dut_if.ras_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ras_full_valid: got %b want 1", dut_if.ras_valid); end
    n_compared++; if (dut_if.pc !== 32'h50) begin n_mismatched++; $display("[TB] FAIL ras_call_pc: got %h want %h", dut_if.pc, 32'h50); end
    dut_if.PCsrc = 2'b00; dut_if.is_call = 1'b0; dut_if.is_ret = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_compared++; if (dut_if.ras_top !== exp_tops[i]) begin n_mismatched++; $display("[TB] FAIL ras_pop_%0d: got %h want %h", i, dut_if.ras_top, exp_tops[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_compared++; if (dut_if.ras_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ras_empty_valid_%0d: got %b want 0", i, dut_if.ras_valid); end
      n_compared++; if (dut_if.ras_top !== 32'h0) begin n_mismatched++; $display("[TB] FAIL ras_empty_top_%0d: got %h want 0", i, dut_if.ras_top); end
    end
    dut_if.is_call = 1'b1;
    tick();
    n_compared++; if (dut_if.ras_top !== 32'h68) begin n_mismatched++; $display("[TB] FAIL ras_both_empty: got %h want %h", dut_if.ras_top, 32'h68); end
    tick();
    n_compared++; if (dut_if.ras_top !== 32'h6C) begin n_mismatched++; $display("[TB] FAIL ras_both_replace: got %h want %h", dut_if.ras_top, 32'h6C); end
    dut_if.is_call = 1'b0;
    tick();
    n_compared++; if (dut_if.ras_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ras_replace_count: got %b want 0", dut_if.ras_valid); end
    dut_if.is_call = 1'b1; dut_if.is_ret = 1'b0; dut_if.PCsrc = 2'b11; dut_if.trap_vec = 32'h1000;
    tick();
    n_compared++; if (dut_if.ras_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ras_trap_priority: got %b want 0", dut_if.ras_valid); end
    n_compared++; if (dut_if.pc !== 32'h1000) begin n_mismatched++; $display("[TB] FAIL ras_trap_pc: got %h want %h", dut_if.pc, 32'h1000); end
`else
    dut_if.PCsrc = 2'b00; dut_if.is_call = 1'b1; dut_if.is_ret = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_compared++; if (dut_if.ras_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL noras_valid_%0d: got %b want 0", i, dut_if.ras_valid); end
      n_compared++; if (dut_if.ras_top !== 32'h0) begin n_mismatched++; $display("[TB] FAIL noras_top_%0d: got %h want 0", i, dut_if.ras_top); end
    end
    n_compared++; if (dut_if.pc !== 32'h8) begin n_mismatched++; $display("[TB] FAIL noras_pc: got %h want %h", dut_if.pc, 32'h8); end
`endif
    dut_if.is_call = 1'b0; dut_if.is_ret = 1'b0;
  endtask

  task automatic test_reset_midcycle();
    dut_if.trap_vec = 32'h80; dut_if.PCsrc = 2'b11; dut_if.is_call = 1'b0; dut_if.is_ret = 1'b0;
    tick();
    n_compared++; if (dut_if.pc !== 32'h80) begin n_mismatched++; $display("[TB] FAIL mid_setup_pc: got %h want %h", dut_if.pc, 32'h80); end
    dut_if.PCsrc = 2'b01; dut_if.ImmOp = 32'h2; dut_if.is_call = 1'b1;
    tick();
    n_compared++; if (dut_if.misalign !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mid_setup_misalign: got %b want 1", dut_if.misalign); end
`ifdef PC_GEN_RAS_EN
    n_compared++; if (dut_if.ras_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL mid_setup_ras: got %b want 1", dut_if.ras_valid); end
`endif
    dut_if.stall = 1'b1; dut_if.is_call = 1'b0; dut_if.PCsrc = 2'b00;
    #3;
    rst = 1'b1;
    #1;
    n_compared++; if (dut_if.pc !== 32'h0) begin n_mismatched++; $display("[TB] FAIL mid_reset_pc: got %h want 0", dut_if.pc); end
    n_compared++; if (dut_if.misalign !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_reset_misalign: got %b want 0", dut_if.misalign); end
    n_compared++; if (dut_if.ras_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mid_reset_ras: got %b want 0", dut_if.ras_valid); end
    @(posedge clk);
    #2;
    n_compared++; if (dut_if.pc !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_hold_pc: got %h want 0", dut_if.pc); end
    rst = 1'b0; dut_if.stall = 1'b0;
    tick();
    n_compared++; if (dut_if.pc !== 32'h4) begin n_mismatched++; $display("[TB] FAIL post_reset_pc: got %h want %h", dut_if.pc, 32'h4); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jalr();
    test_stall();
    test_ras();
    test_reset_midcycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
